// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central pipeline control for the 5-stage in-order core. It resolves load-use
//   stalls, branch flushes and data-memory wait freezes into the pipeline-register
//   enables and flushes. It also selects the EX/ID operand forwarding paths.
//   Saturating stall/flush performance counters and a sticky memory-timeout flag
//   are kept here as well.
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   id_*                   register indices and usage of the instruction in ID
//   id_ex_*                indices, write and load flags of the instruction in EX
//   ex_mem_*               dest, write, load, store and taken-branch flags in MEM
//   mem_wb_*               dest and write flag of the instruction in WB
//   dmem_ready             data memory completes the current access this cycle
//   *_enable, *_flush      pipeline register control (combinational)
//   fwd_a_sel, fwd_b_sel   EX operand source: 00 regfile, 01 EX/MEM, 10 WB
//   id_byp_a, id_byp_b     ID operand takes WB data (write-through)
//   mem_timeout            sticky flag: one mem op waited MEM_TIMEOUT cycles
//   stall_cnt, flush_cnt   saturating performance counters
module pipe_hazard_ctrl #(
    parameter int NREG        = 32,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16,
    localparam int RW         = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RW-1:0]    id_rs1_idx,
    input  logic [RW-1:0]    id_rs2_idx,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [RW-1:0]    id_ex_rs1_idx,
    input  logic [RW-1:0]    id_ex_rs2_idx,
    input  logic [RW-1:0]    id_ex_dest_idx,
    input  logic             id_ex_reg_wr,
    input  logic             id_ex_rd_mem,
    input  logic [RW-1:0]    ex_mem_dest_idx,
    input  logic             ex_mem_reg_wr,
    input  logic             ex_mem_rd_mem,
    input  logic             ex_mem_wr_mem,
    input  logic             ex_mem_take_branch,
    input  logic [RW-1:0]    mem_wb_dest_idx,
    input  logic             mem_wb_reg_wr,
    input  logic             dmem_ready,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             id_ex_enable,
    output logic             ex_mem_enable,
    output logic             mem_wb_enable,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             id_byp_a,
    output logic             id_byp_b,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MEMWAIT = 1'b1;

    logic [0:0]    state;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic          freeze;
    logic          flush;
    logic          load_use;

    // Producer x writes a non-zero register that matches idx.
    function automatic logic hit(input logic wr, input logic [RW-1:0] dest,
                                 input logic [RW-1:0] idx);
        return wr && (dest != '0) && (dest == idx);
    endfunction

    assign freeze   = (ex_mem_rd_mem || ex_mem_wr_mem) && !dmem_ready;
    assign flush    = ex_mem_take_branch && !freeze;
    assign load_use = id_ex_rd_mem &&
                      ((id_rs1_used && hit(id_ex_reg_wr, id_ex_dest_idx, id_rs1_idx)) ||
                       (id_rs2_used && hit(id_ex_reg_wr, id_ex_dest_idx, id_rs2_idx)));

    // Freeze holds everything, including a pending branch, until memory answers.
    always_comb begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        if (freeze) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_enable = 1'b0;
        end else if (flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    // A load result in EX/MEM is not available yet, so it never forwards from there.
    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (hit(ex_mem_reg_wr, ex_mem_dest_idx, id_ex_rs1_idx) && !ex_mem_rd_mem)
            fwd_a_sel = 2'b01;
        else if (hit(mem_wb_reg_wr, mem_wb_dest_idx, id_ex_rs1_idx))
            fwd_a_sel = 2'b10;
        if (hit(ex_mem_reg_wr, ex_mem_dest_idx, id_ex_rs2_idx) && !ex_mem_rd_mem)
            fwd_b_sel = 2'b01;
        else if (hit(mem_wb_reg_wr, mem_wb_dest_idx, id_ex_rs2_idx))
            fwd_b_sel = 2'b10;
    end

    assign id_byp_a = hit(mem_wb_reg_wr, mem_wb_dest_idx, id_rs1_idx);
    assign id_byp_b = hit(mem_wb_reg_wr, mem_wb_dest_idx, id_rs2_idx);

    // wait_cnt counts frozen cycles of the current mem op, the entry cycle included.
    always_comb begin
        wait_nxt = '0;
        if (freeze) begin
            if (state == ST_RUN)
                wait_nxt = WW'(1);
            else if (wait_cnt == WAIT_MAX)
                wait_nxt = wait_cnt;
            else
                wait_nxt = wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= freeze ? ST_MEMWAIT : ST_RUN;
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_MAX)
                mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_enable && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: expected control words go into a scoreboard queue
// when stimulus is driven and are popped and compared against the outputs.
// Control word bits: {pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush,
// id_ex_flush, fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b}.
module tb_pipe_hazard_ctrl;

    localparam int NREG = 32;
    localparam int TMO  = 4;
    localparam int CW   = 4;
    localparam int RW   = 5;
    localparam logic [CW-1:0] MAXC = '1;

    localparam logic [12:0] C_NORM = 13'b11111_00_00_00_00;
    localparam logic [12:0] C_LU   = 13'b00111_01_00_00_00;
    localparam logic [12:0] C_FL   = 13'b11111_11_00_00_00;
    localparam logic [12:0] C_FRZ  = 13'b00000_00_00_00_00;

    logic clk = 1'b0;
    logic rst;
    logic [RW-1:0] id_rs1_idx, id_rs2_idx, id_ex_rs1_idx, id_ex_rs2_idx, id_ex_dest_idx;
    logic [RW-1:0] ex_mem_dest_idx, mem_wb_dest_idx;
    logic id_rs1_used, id_rs2_used, id_ex_reg_wr, id_ex_rd_mem;
    logic ex_mem_reg_wr, ex_mem_rd_mem, ex_mem_wr_mem, ex_mem_take_branch;
    logic mem_wb_reg_wr, dmem_ready;
    logic pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable;
    logic if_id_flush, id_ex_flush, id_byp_a, id_byp_b, mem_timeout;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [12:0] obs;

    logic [12:0] sbq[$];
    logic [12:0] e;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
    int unsigned m_wait = 0;
    logic m_tmo = 1'b0;

    always #5 clk = ~clk;

    assign obs = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable,
                  if_id_flush, id_ex_flush, fwd_a_sel, fwd_b_sel, id_byp_a, id_byp_b};

    pipe_hazard_ctrl #(.NREG(NREG), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_ex_rs1_idx(id_ex_rs1_idx), .id_ex_rs2_idx(id_ex_rs2_idx),
        .id_ex_dest_idx(id_ex_dest_idx), .id_ex_reg_wr(id_ex_reg_wr),
        .id_ex_rd_mem(id_ex_rd_mem),
        .ex_mem_dest_idx(ex_mem_dest_idx), .ex_mem_reg_wr(ex_mem_reg_wr),
        .ex_mem_rd_mem(ex_mem_rd_mem), .ex_mem_wr_mem(ex_mem_wr_mem),
        .ex_mem_take_branch(ex_mem_take_branch),
        .mem_wb_dest_idx(mem_wb_dest_idx), .mem_wb_reg_wr(mem_wb_reg_wr),
        .dmem_ready(dmem_ready),
        .pc_enable(pc_enable), .if_id_enable(if_id_enable), .id_ex_enable(id_ex_enable),
        .ex_mem_enable(ex_mem_enable), .mem_wb_enable(mem_wb_enable),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic set_idle();
        id_rs1_idx = '0; id_rs2_idx = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_ex_rs1_idx = '0; id_ex_rs2_idx = '0; id_ex_dest_idx = '0;
        id_ex_reg_wr = 1'b0; id_ex_rd_mem = 1'b0;
        ex_mem_dest_idx = '0; ex_mem_reg_wr = 1'b0; ex_mem_rd_mem = 1'b0;
        ex_mem_wr_mem = 1'b0; ex_mem_take_branch = 1'b0;
        mem_wb_dest_idx = '0; mem_wb_reg_wr = 1'b0; dmem_ready = 1'b1;
    endtask

    // Reference model of the registered state, advanced by one expected control word.
    task automatic model_step(input logic [12:0] x);
        if (!x[12] && m_stall < MAXC) m_stall++;
        if (x[7] && m_flush < MAXC) m_flush++;
        if (!x[9]) begin
            m_wait++;
            if (m_wait >= TMO) m_tmo = 1'b1;
        end else begin
            m_wait = 0;
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        sbq.push_back(C_NORM);
        #2;
        e = sbq.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL reset_ctl: got %b exp %b", obs, e); else n_pass++;
        n_chk++;
        if (stall_cnt !== '0 || flush_cnt !== '0 || mem_timeout !== 1'b0)
            $display("FAIL reset_regs: got stall=%0d flush=%0d tmo=%b exp 0 0 0",
                     stall_cnt, flush_cnt, mem_timeout);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [12:0] tbl_exp [5] = '{C_LU, C_NORM, C_LU, C_NORM, C_NORM};
        logic        tbl_ld  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0]  tbl_dst [5] = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd0};
        logic [4:0]  tbl_rs1 [5] = '{5'd5, 5'd5, 5'd1, 5'd5, 5'd0};
        logic        tbl_u1  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0]  tbl_rs2 [5] = '{5'd1, 5'd1, 5'd5, 5'd1, 5'd0};
        for (int i = 0; i < 5; i++) begin
            set_idle();
            id_ex_reg_wr = 1'b1;
            id_ex_rd_mem = tbl_ld[i]; id_ex_dest_idx = tbl_dst[i];
            id_rs1_idx = tbl_rs1[i]; id_rs1_used = tbl_u1[i];
            id_rs2_idx = tbl_rs2[i]; id_rs2_used = 1'b1;
            sbq.push_back(tbl_exp[i]);
            #2;
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL load_use[%0d]: got %b exp %b", i, obs, e);
            else n_pass++;
            model_step(e);
            @(posedge clk); #1;
            n_chk++;
            if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush))
                $display("FAIL load_use_cnt[%0d]: got stall=%0d flush=%0d exp %0d %0d",
                         i, stall_cnt, flush_cnt, m_stall, m_flush);
            else n_pass++;
        end
    endtask

    task automatic test_forward();
        logic [12:0] tbl_exp [5] = '{13'b11111_00_01_01_10, 13'b11111_00_10_10_10,
                                     13'b11111_00_10_10_01, C_NORM, 13'b11111_00_10_01_11};
        logic [4:0]  tbl_emd [5] = '{5'd3, 5'd3, 5'd3, 5'd0, 5'd3};
        logic        tbl_emw [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        tbl_eml [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [4:0]  tbl_wbd [5] = '{5'd3, 5'd3, 5'd3, 5'd0, 5'd7};
        logic [4:0]  tbl_xa  [5] = '{5'd3, 5'd3, 5'd3, 5'd0, 5'd7};
        logic [4:0]  tbl_xb  [5] = '{5'd3, 5'd3, 5'd3, 5'd0, 5'd3};
        logic [4:0]  tbl_ia  [5] = '{5'd3, 5'd3, 5'd4, 5'd0, 5'd7};
        logic [4:0]  tbl_ib  [5] = '{5'd4, 5'd4, 5'd3, 5'd0, 5'd7};
        for (int i = 0; i < 5; i++) begin
            set_idle();
            ex_mem_dest_idx = tbl_emd[i]; ex_mem_reg_wr = tbl_emw[i];
            ex_mem_rd_mem = tbl_eml[i];
            mem_wb_dest_idx = tbl_wbd[i]; mem_wb_reg_wr = 1'b1;
            id_ex_rs1_idx = tbl_xa[i]; id_ex_rs2_idx = tbl_xb[i];
            id_rs1_idx = tbl_ia[i]; id_rs2_idx = tbl_ib[i];
            sbq.push_back(tbl_exp[i]);
            #2;
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL forward[%0d]: got %b exp %b", i, obs, e);
            else n_pass++;
            model_step(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_over_load_use();
        set_idle();
        id_ex_reg_wr = 1'b1; id_ex_rd_mem = 1'b1; id_ex_dest_idx = 5'd5;
        id_rs1_idx = 5'd5; id_rs1_used = 1'b1;
        ex_mem_take_branch = 1'b1;
        sbq.push_back(C_FL);
        #2;
        e = sbq.pop_front();
        n_chk++;
        if (obs !== e) $display("FAIL flush_ctl: got %b exp %b", obs, e); else n_pass++;
        model_step(e);
        @(posedge clk); #1;
        n_chk++;
        if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush))
            $display("FAIL flush_cnt: got stall=%0d flush=%0d exp %0d %0d",
                     stall_cnt, flush_cnt, m_stall, m_flush);
        else n_pass++;
    endtask

    // Store waits three cycles with a taken branch held behind it.
    task automatic test_freeze_store();
        for (int i = 0; i < 4; i++) begin
            set_idle();
            ex_mem_wr_mem = 1'b1; ex_mem_take_branch = 1'b1;
            dmem_ready = (i == 3);
            sbq.push_back((i == 3) ? C_FL : C_FRZ);
            #2;
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL freeze_ctl[%0d]: got %b exp %b", i, obs, e);
            else n_pass++;
            model_step(e);
            @(posedge clk); #1;
            n_chk++;
            if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush) || mem_timeout !== m_tmo)
                $display("FAIL freeze_regs[%0d]: got stall=%0d flush=%0d tmo=%b exp %0d %0d %b",
                         i, stall_cnt, flush_cnt, mem_timeout, m_stall, m_flush, m_tmo);
            else n_pass++;
        end
    endtask

    // Load waits n cycles then completes; also used for counter saturation.
    task automatic test_timeout(input int n, input string tag);
        for (int i = 0; i <= n; i++) begin
            set_idle();
            ex_mem_rd_mem = 1'b1;
            dmem_ready = (i == n);
            sbq.push_back((i == n) ? C_NORM : C_FRZ);
            #2;
            e = sbq.pop_front();
            n_chk++;
            if (obs !== e) $display("FAIL %s_ctl[%0d]: got %b exp %b", tag, i, obs, e);
            else n_pass++;
            model_step(e);
            @(posedge clk); #1;
            n_chk++;
            if (stall_cnt !== CW'(m_stall) || mem_timeout !== m_tmo)
                $display("FAIL %s_regs[%0d]: got stall=%0d tmo=%b exp %0d %b",
                         tag, i, stall_cnt, mem_timeout, m_stall, m_tmo);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midwait();
        set_idle();
        ex_mem_rd_mem = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            model_step(C_FRZ);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        sbq.push_back(C_FRZ);
        #1;
        e = sbq.pop_front();
        m_stall = 0; m_flush = 0; m_wait = 0; m_tmo = 1'b0;
        n_chk++;
        if (obs !== e || stall_cnt !== '0 || flush_cnt !== '0 || mem_timeout !== 1'b0)
            $display("FAIL rst_midwait: got ctl=%b stall=%0d flush=%0d tmo=%b exp %b 0 0 0",
                     obs, stall_cnt, flush_cnt, mem_timeout, e);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        // Wait counter must restart from zero after reset.
        for (int i = 0; i < 4; i++) begin
            model_step(C_FRZ);
            @(posedge clk); #1;
            n_chk++;
            if (stall_cnt !== CW'(m_stall) || mem_timeout !== m_tmo)
                $display("FAIL rst_rewait[%0d]: got stall=%0d tmo=%b exp %0d %b",
                         i, stall_cnt, mem_timeout, m_stall, m_tmo);
            else n_pass++;
        end
        set_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_flush_over_load_use();
        test_freeze_store();
        test_timeout(6, "timeout");
        test_timeout(8, "saturate");
        test_reset_midwait();
        n_chk++;
        if (sbq.size() != 0) $display("FAIL scoreboard_empty: got %0d left exp 0", sbq.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
